// File: rtl/prim_alert_transmitter.sv
// Alert transmitter: turns local alert requests and incoming pings into the
// four-phase differential alert handshake. Optional watchdog: PRIM_ALERT_TX_TIMEOUT_EN.
module prim_alert_transmitter #(
    parameter int unsigned TimeoutCycles = 256,
    parameter int unsigned CntW          = 9
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       alert_req_i,
    output logic       alert_ack_o,
    output logic       integ_fail_o,
    output logic       hs_timeout_o,
    input  logic [3:0] alert_rx_i,
    output logic [1:0] alert_tx_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HSA1   = 3'd1;
    localparam logic [2:0] ST_HSA2   = 3'd2;
    localparam logic [2:0] ST_HSP1   = 3'd3;
    localparam logic [2:0] ST_HSP2   = 3'd4;
    localparam logic [2:0] ST_PAUSE0 = 3'd5;
    localparam logic [2:0] ST_PAUSE1 = 3'd6;
    localparam logic [2:0] ST_SIGINT = 3'd7;

    // rx_q = {ping_p, ping_n, ack_p, ack_n}; idle levels are ping=01, ack=01.
    logic [3:0] rx_q;
    logic       ping_p_q2;
    logic [2:0] state_q, state_d;
    logic [1:0] tx_q, tx_d;
    logic       alert_pend_q, ping_pend_q;

    logic ack_lvl, sig_int, ping_evt, ack_done, hs_to;

    always_comb begin
        ack_lvl  = rx_q[1];
        sig_int  = (rx_q[1] == rx_q[0]) | (rx_q[3] == rx_q[2]);
        ping_evt = (rx_q[3] != ping_p_q2) & ~sig_int;
        ack_done = (state_q == ST_HSA2) & ~ack_lvl & ~sig_int;
    end

`ifdef PRIM_ALERT_TX_TIMEOUT_EN
    logic [CntW-1:0] cnt_q;
    logic            in_hs, hs_prog;

    always_comb begin
        in_hs   = 1'b0;
        hs_prog = 1'b0;
        case (state_q)
            ST_HSA1, ST_HSP1: begin in_hs = 1'b1; hs_prog = ack_lvl;  end
            ST_HSA2, ST_HSP2: begin in_hs = 1'b1; hs_prog = ~ack_lvl; end
            default: ;
        endcase
        // A phase that is making progress this cycle never times out, so the
        // timeout pulse can never coincide with alert_ack_o.
        hs_to = in_hs & ~sig_int & ~hs_prog & (cnt_q == CntW'(TimeoutCycles - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (in_hs) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign hs_to = 1'b0;
`endif

    // Handshake: raise alert (tx=10), wait for ack_p high, drop alert (tx=01),
    // wait for ack_p low, then hold off two cycles before the next handshake.
    always_comb begin
        state_d = state_q;
        if (sig_int) begin
            state_d = ST_SIGINT;
        end else if (hs_to) begin
            state_d = ST_PAUSE0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (alert_pend_q)     state_d = ST_HSA1;
                    else if (ping_pend_q) state_d = ST_HSP1;
                end
                ST_HSA1:   if (ack_lvl)  state_d = ST_HSA2;
                ST_HSA2:   if (!ack_lvl) state_d = ST_PAUSE0;
                ST_HSP1:   if (ack_lvl)  state_d = ST_HSP2;
                ST_HSP2:   if (!ack_lvl) state_d = ST_PAUSE0;
                ST_PAUSE0: state_d = ST_PAUSE1;
                ST_PAUSE1: state_d = ST_IDLE;
                ST_SIGINT: state_d = ST_PAUSE0;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_d = 2'b01;
        case (state_d)
            ST_HSA1, ST_HSP1: tx_d = 2'b10;
            ST_SIGINT:        tx_d = (state_q == ST_SIGINT) ? ~tx_q : 2'b11;
            default:          tx_d = 2'b01;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_q         <= 4'b0101;
            ping_p_q2    <= 1'b0;
            state_q      <= ST_IDLE;
            tx_q         <= 2'b01;
            alert_pend_q <= 1'b0;
            ping_pend_q  <= 1'b0;
        end else begin
            rx_q      <= alert_rx_i;
            ping_p_q2 <= rx_q[3];
            state_q   <= state_d;
            tx_q      <= tx_d;
            if (state_d == ST_HSA1 && state_q != ST_HSA1) alert_pend_q <= alert_req_i;
            else                                          alert_pend_q <= alert_pend_q | alert_req_i;
            if (state_d == ST_HSP1 && state_q != ST_HSP1) ping_pend_q <= ping_evt;
            else                                          ping_pend_q <= ping_pend_q | ping_evt;
        end
    end

    assign alert_tx_o   = tx_q;
    assign alert_ack_o  = ack_done;
    assign integ_fail_o = (state_q == ST_SIGINT);
    assign hs_timeout_o = hs_to;

endmodule

// File: tb/tb_prim_alert_transmitter.sv
// Bench for prim_alert_transmitter: directed stimulus, expected output events
// queued per scenario and matched by a negedge monitor.
module tb_prim_alert_transmitter;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       alert_req_i = 1'b0;
    logic [3:0] alert_rx_i = 4'b0101;
    logic       alert_ack_o, integ_fail_o, hs_timeout_o;
    logic [1:0] alert_tx_o;

    int         cyc = 0;
    int         base = 0;
    int         checks = 0;
    int         failures = 0;
    logic       rst_at_edge = 1'b1;
    logic       snap_req = 1'b0;
    logic [1:0] prev_tx = 2'b01;
    logic       prev_integ = 1'b0;
    // Event word: {cycle relative to scenario start, ack, timeout, integ, tx}
    logic [20:0] exp_q[$];

`ifdef PRIM_ALERT_TX_TIMEOUT_EN
    prim_alert_transmitter #(.TimeoutCycles(16), .CntW(5)) dut (
`else
    prim_alert_transmitter dut (
`endif
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alert_req_i  (alert_req_i),
        .alert_ack_o  (alert_ack_o),
        .integ_fail_o (integ_fail_o),
        .hs_timeout_o (hs_timeout_o),
        .alert_rx_i   (alert_rx_i),
        .alert_tx_o   (alert_tx_o)
    );

    // clock / reset bookkeeping
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst_i;
    end

    // monitor: log every output change, ack/timeout pulse, or requested snapshot
    always @(negedge clk_i) begin
        logic [20:0] act_w, exp_w;
        logic        log_it;
        act_w  = {16'(cyc - base), alert_ack_o, hs_timeout_o, integ_fail_o, alert_tx_o};
        log_it = snap_req || (!rst_at_edge && (alert_tx_o != prev_tx || alert_ack_o ||
                 hs_timeout_o || integ_fail_o != prev_integ));
        if (snap_req) snap_req = 1'b0;
        if (log_it) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event act rel=%0d ack=%b to=%b integ=%b tx=%b req=none",
                         act_w[20:5], act_w[4], act_w[3], act_w[2], act_w[1:0]);
            end else begin
                exp_w = exp_q.pop_front();
                if (act_w !== exp_w) begin
                    failures++;
                    $display("FAIL event act rel=%0d ack=%b to=%b integ=%b tx=%b req rel=%0d ack=%b to=%b integ=%b tx=%b",
                             act_w[20:5], act_w[4], act_w[3], act_w[2], act_w[1:0],
                             exp_w[20:5], exp_w[4], exp_w[3], exp_w[2], exp_w[1:0]);
                end
            end
        end
        prev_tx    = alert_tx_o;
        prev_integ = integ_fail_o;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic goto_rel(input int rel);
        while (cyc < base + rel) tick();
    endtask

    task automatic start_scn();
        base = cyc;
    endtask

    task automatic exp_ev(input int rel, input logic a, input logic t, input logic i,
                          input logic [1:0] tx);
        exp_q.push_back({16'(rel), a, t, i, tx});
    endtask

    initial begin
        // 1: reset with random rx
        for (int k = 0; k < 3; k++) begin
            alert_rx_i = 4'($urandom_range(0, 15));
            tick();
        end
        start_scn();
        exp_ev(0, 1'b0, 1'b0, 1'b0, 2'b01);
        snap_req    = 1'b1;
        rst_i       = 1'b0;
        alert_rx_i  = 4'b0101;
        goto_rel(3);

        // 2: single alert, ack after 3 cycles in HsA1
        start_scn();
        exp_ev(2, 1'b0, 1'b0, 1'b0, 2'b10);
        exp_ev(7, 1'b0, 1'b0, 1'b0, 2'b01);
        exp_ev(9, 1'b1, 1'b0, 1'b0, 2'b01);
        alert_req_i = 1'b1;
        goto_rel(1); alert_req_i = 1'b0;
        goto_rel(5); alert_rx_i = 4'b0110;
        goto_rel(8); alert_rx_i = 4'b0101;
        goto_rel(14);

        // 3: ping toggle 01->10, no alert_ack_o
        start_scn();
        exp_ev(3, 1'b0, 1'b0, 1'b0, 2'b10);
        exp_ev(6, 1'b0, 1'b0, 1'b0, 2'b01);
        alert_rx_i = 4'b1001;
        goto_rel(4); alert_rx_i = 4'b1010;
        goto_rel(7); alert_rx_i = 4'b1001;
        goto_rel(13);

        // 4: alert and ping together; alert first, ping after the pause
        start_scn();
        exp_ev(2,  1'b0, 1'b0, 1'b0, 2'b10);
        exp_ev(5,  1'b0, 1'b0, 1'b0, 2'b01);
        exp_ev(7,  1'b1, 1'b0, 1'b0, 2'b01);
        exp_ev(11, 1'b0, 1'b0, 1'b0, 2'b10);
        exp_ev(14, 1'b0, 1'b0, 1'b0, 2'b01);
        alert_req_i = 1'b1; alert_rx_i = 4'b0101;
        goto_rel(1);  alert_req_i = 1'b0;
        goto_rel(3);  alert_rx_i = 4'b0110;
        goto_rel(6);  alert_rx_i = 4'b0101;
        goto_rel(12); alert_rx_i = 4'b0110;
        goto_rel(15); alert_rx_i = 4'b0101;
        goto_rel(20);

        // 5a: ack pair 11 for 4 cycles in HsA1, pending ping served afterwards
        start_scn();
        exp_ev(2,  1'b0, 1'b0, 1'b0, 2'b10);
        exp_ev(5,  1'b0, 1'b0, 1'b1, 2'b11);
        exp_ev(6,  1'b0, 1'b0, 1'b1, 2'b00);
        exp_ev(7,  1'b0, 1'b0, 1'b1, 2'b11);
        exp_ev(8,  1'b0, 1'b0, 1'b1, 2'b00);
        exp_ev(9,  1'b0, 1'b0, 1'b0, 2'b01);
        exp_ev(12, 1'b0, 1'b0, 1'b0, 2'b10);
        exp_ev(15, 1'b0, 1'b0, 1'b0, 2'b01);
        alert_req_i = 1'b1; alert_rx_i = 4'b1001;
        goto_rel(1);  alert_req_i = 1'b0;
        goto_rel(3);  alert_rx_i = 4'b1011;
        goto_rel(7);  alert_rx_i = 4'b1001;
        goto_rel(13); alert_rx_i = 4'b1010;
        goto_rel(16); alert_rx_i = 4'b1001;
        goto_rel(21);

        // 5b: reset during SigInt discards the pending ping
        start_scn();
        exp_ev(2, 1'b0, 1'b0, 1'b0, 2'b10);
        exp_ev(5, 1'b0, 1'b0, 1'b1, 2'b11);
        exp_ev(6, 1'b0, 1'b0, 1'b1, 2'b00);
        exp_ev(7, 1'b0, 1'b0, 1'b0, 2'b01);
        alert_req_i = 1'b1; alert_rx_i = 4'b0101;
        goto_rel(1); alert_req_i = 1'b0;
        goto_rel(3); alert_rx_i = 4'b0111;
        goto_rel(6); rst_i = 1'b1;
        goto_rel(7); snap_req = 1'b1;
        goto_rel(8); rst_i = 1'b0; alert_rx_i = 4'b0101;
        goto_rel(16);

        // 6: receiver never acks
        start_scn();
        exp_ev(2, 1'b0, 1'b0, 1'b0, 2'b10);
`ifdef PRIM_ALERT_TX_TIMEOUT_EN
        exp_ev(17, 1'b0, 1'b1, 1'b0, 2'b10);
        exp_ev(18, 1'b0, 1'b0, 1'b0, 2'b01);
        exp_ev(30, 1'b0, 1'b0, 1'b0, 2'b01);
`else
        exp_ev(30, 1'b0, 1'b0, 1'b0, 2'b10);
`endif
        alert_req_i = 1'b1;
        goto_rel(1);  alert_req_i = 1'b0;
        goto_rel(30); snap_req = 1'b1;
        goto_rel(33);

        // final report
        while (exp_q.size() > 0) begin
            logic [20:0] miss_w;
            miss_w = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event act=none req rel=%0d ack=%b to=%b integ=%b tx=%b",
                     miss_w[20:5], miss_w[4], miss_w[3], miss_w[2], miss_w[1:0]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
